// File: rtl/btn_pkg.sv
// Shared constants for the Shady Pong button conditioning path: bus layout,
// default timing derived from the 25 MHz pixel clock, and the repeat FSM encoding.
package btn_pkg;

  localparam int unsigned CLK_HZ       = 25_000_000;
  localparam int unsigned NUM_BTNS_DEF = 4;

  localparam int unsigned BTN_P1_UP    = 3;
  localparam int unsigned BTN_P1_DOWN  = 2;
  localparam int unsigned BTN_P2_UP    = 1;
  localparam int unsigned BTN_P2_DOWN  = 0;

  // 5 ms debounce, 0.5 s first repeat, 100 ms repeat spacing
  localparam int unsigned DEBOUNCE_CYCLES_DEF = CLK_HZ / 200;
  localparam int unsigned REPEAT_DELAY_DEF    = CLK_HZ / 2;
  localparam int unsigned REPEAT_PERIOD_DEF   = CLK_HZ / 10;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_PERIOD = 2'd2
  } rpt_state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, restart-on-glitch debouncer, press/release
// pulses and, when BTN_AUTOREPEAT_EN is defined, hold-to-repeat press pulses.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic CLK,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rls
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("btn_debounce_ch: illegal timing parameters");
  end

  logic             sync1;
  logic             sync0;
  logic             stb;
  logic [CNT_W-1:0] cnt;
  logic             press_q;
  logic             rls_q;
  logic             hit_c;
  logic             rise_c;
  logic             fall_c;
  logic             rpt_fire_c;

  // A toggle is accepted on the DEBOUNCE_CYCLES-th consecutive differing sample
  assign hit_c  = (sync0 != stb) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign rise_c = hit_c && !stb;
  assign fall_c = hit_c && stb;

  always_ff @(posedge CLK) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync0   <= 1'b0;
      stb     <= 1'b0;
      cnt     <= '0;
      press_q <= 1'b0;
      rls_q   <= 1'b0;
    end else begin
      sync1   <= raw;
      sync0   <= sync1;
      if (sync0 == stb) begin
        cnt <= '0;
      end else if (hit_c) begin
        stb <= ~stb;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      press_q <= rise_c | rpt_fire_c;
      rls_q   <= fall_c;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = cnt_width(RPT_MAX);

  rpt_state_t       rpt_state;
  rpt_state_t       rpt_next;
  logic [RPT_W-1:0] rcnt;
  logic [RPT_W-1:0] rcnt_next;

  always_ff @(posedge CLK) begin
    if (rst) begin
      rpt_state <= RPT_IDLE;
      rcnt      <= '0;
    end else begin
      rpt_state <= rpt_next;
      rcnt      <= rcnt_next;
    end
  end

  // Counting starts in the first cycle the level reads 1; a release cancels at once
  always_comb begin
    rpt_next   = rpt_state;
    rcnt_next  = rcnt;
    rpt_fire_c = 1'b0;
    case (rpt_state)
      RPT_IDLE: begin
        rcnt_next = '0;
        if (rise_c) rpt_next = RPT_DELAY;
      end
      RPT_DELAY: begin
        if (rcnt == RPT_W'(REPEAT_DELAY - 1)) begin
          rpt_fire_c = 1'b1;
          rcnt_next  = '0;
          rpt_next   = RPT_PERIOD;
        end else begin
          rcnt_next = rcnt + RPT_W'(1);
        end
      end
      RPT_PERIOD: begin
        if (rcnt == RPT_W'(REPEAT_PERIOD - 1)) begin
          rpt_fire_c = 1'b1;
          rcnt_next  = '0;
        end else begin
          rcnt_next = rcnt + RPT_W'(1);
        end
      end
      default: begin
        rpt_next  = RPT_IDLE;
        rcnt_next = '0;
      end
    endcase
    if (fall_c) begin
      rpt_next   = RPT_IDLE;
      rcnt_next  = '0;
      rpt_fire_c = 1'b0;
    end
  end
`else
  assign rpt_fire_c = 1'b0;
`endif

  assign level = stb;
  assign press = press_q;
  assign rls   = rls_q;

endmodule

// File: rtl/btn_conditioner.sv
// Synchronises and debounces the raw paddle buttons for the game core's btns bus.
// Define BTN_AUTOREPEAT_EN to add hold-to-repeat pulses on btn_press.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned NUM_BTNS        = NUM_BTNS_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic                CLK,
  input  logic                rst,
  input  logic [NUM_BTNS-1:0] btn_raw,
  output logic [NUM_BTNS-1:0] btns,
  output logic [NUM_BTNS-1:0] btn_press,
  output logic [NUM_BTNS-1:0] btn_release
);

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .CLK   (CLK),
      .rst   (rst),
      .raw   (btn_raw[i]),
      .level (btns[i]),
      .press (btn_press[i]),
      .rls   (btn_release[i])
    );
  end

endmodule
